// File: rtl/muldiv_hilo_unit_if.sv
// Request/result bundle between the MIPS datapath and the HI/LO multiply/divide unit.
interface muldiv_hilo_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            mthi;
  logic            mtlo;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on operand magnitudes for XLEN cycles, then applies sign correction in one cycle.
module muldiv_hilo_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  muldiv_hilo_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  logic [XLEN-1:0]   raw_a_q, raw_a_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dbz_q, dbz_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_out_q, dbz_out_d;

  logic              a_neg, b_neg;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod;

  // Signedness is op[0]==0 for both MULT and DIV.
  assign a_neg   = ~bus.op[0] & bus.operand_a[XLEN-1];
  assign b_neg   = ~bus.op[0] & bus.operand_b[XLEN-1];
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
  // Dividend bits enter the remainder from the MSB of mag_a, which shifts left each step.
  assign rem_sh  = {acc_q[2*XLEN-1:XLEN], mag_a_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, mag_b_q};
  assign prod    = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    raw_a_d   = raw_a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d      = bus.op;
          mag_a_d   = a_neg ? -bus.operand_a : bus.operand_a;
          mag_b_d   = b_neg ? -bus.operand_b : bus.operand_b;
          raw_a_d   = bus.operand_a;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dbz_d     = bus.op[1] & (bus.operand_b == '0);
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = StCalc;
        end else begin
          if (bus.mthi) hi_d = bus.operand_a;
          if (bus.mtlo) lo_d = bus.operand_a;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          mag_a_d = mag_a_q << 1;
        end else begin
          acc_d   = {mul_sum, acc_q[XLEN-1:1]};
          mag_b_d = mag_b_q >> 1;
        end
        if (cnt_q == CntW'(XLEN - 1)) state_d = StSign;
      end
      StSign: begin
        state_d   = StIdle;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        if (!op_q[1]) begin
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end else if (dbz_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
          lo_d = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      raw_a_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      raw_a_q   <= raw_a_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed corner cases plus random ops
// checked against a plain 64-bit arithmetic model.
module tb_muldiv_hilo_unit;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  muldiv_hilo_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_hilo_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p, uq, ur;
    sa  = $signed(a);
    sb  = $signed(b);
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          dbz = 1'b1; hi = a; lo = 32'hFFFFFFFF;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          p = q; lo = p[31:0];
          p = r; hi = p[31:0];
        end else begin
          uq = {32'b0, a} / {32'b0, b}; ur = {32'b0, a} % {32'b0, b};
          lo = uq[31:0]; hi = ur[31:0];
        end
      end
    endcase
  endfunction

  // Issues one op from IDLE (called with time just after an edge) and checks its result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string name);
    logic [31:0] eh, el, h0, l0;
    logic        edbz;
    int          cyc;
    bit          held, got;
    model(op, a, b, eh, el, edbz);
    h0 = bus.hi; l0 = bus.lo; held = 1'b1; got = 1'b0; cyc = 0;
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.operand_a = $urandom; bus.operand_b = $urandom;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, bus.busy, bus.done);
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      cyc = i;
      if (bus.done === 1'b1) begin got = 1'b1; break; end
      if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
      if (disturb && i == 10) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        bus.operand_a = 32'h1234; bus.operand_b = 32'h5;
      end
      if (disturb && i == 11) begin
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      end
    end
    n_tests++;
    if (!got || cyc != 33) begin
      n_fail++; $display("FAIL %s latency: got done=%b after %0d cycles, required 33", name, got, cyc);
    end
    n_tests++;
    if (!held) begin
      n_fail++; $display("FAIL %s hold: hi/lo changed during CALC, required stable %h/%h", name, h0, l0);
    end
    n_tests++;
    if (bus.hi !== eh || bus.lo !== el || bus.div_by_zero !== edbz || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: hi=%h lo=%h dbz=%b busy=%b required hi=%h lo=%h dbz=%b busy=0",
               name, bus.hi, bus.lo, bus.div_by_zero, bus.busy, eh, el, edbz);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
        bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h required all zero",
                         bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, "mult_neg3x7");
    run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, "mult_minxmin");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg7by2");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100by7");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_min_by_neg1");
  endtask

  task automatic test_div_by_zero();
    run_op(2'b11, 32'd100, 32'd0, 1'b0, "divu_by_zero");
    run_op(2'b10, 32'hFFFFFF00, 32'd0, 1'b0, "div_by_zero_neg");
    run_op(2'b11, 32'd50, 32'd5, 1'b0, "divu_after_zero");
  endtask

  task automatic test_ignore_and_moves();
    run_op(2'b01, 32'h00012345, 32'h000ABCDE, 1'b1, "multu_disturbed");
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.operand_a = 32'hCAFE;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    n_tests++;
    if (bus.hi !== 32'hCAFE || bus.lo !== 32'hCAFE || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL mthi_mtlo: hi=%h lo=%h done=%b busy=%b required CAFE/CAFE/0/0",
                         bus.hi, bus.lo, bus.done, bus.busy);
    end
    bus.mtlo = 1'b1; bus.operand_a = 32'h600D;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    n_tests++;
    if (bus.hi !== 32'hCAFE || bus.lo !== 32'h600D) begin
      n_fail++; $display("FAIL mtlo_only: hi=%h lo=%h required CAFE/600D", bus.hi, bus.lo);
    end
    // start with mthi in IDLE: the move must not disturb HI during CALC
    bus.mthi = 1'b1;
    run_op(2'b00, 32'd9, 32'hFFFFFFFE, 1'b0, "start_beats_mthi");
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required all zero",
                         bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b00, 32'hFFFF0001, 32'h00012345, 1'b0, "mult_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(op, a, b, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_ignore_and_moves();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
